carrier_loop_ctrl: RTL

//  Mode controller for the BPSK carrier-recovery loop filter. Watches the phase-detector error

---
 rtl/carrier_loop_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/carrier_loop_ctrl.sv
// Mode controller for the BPSK carrier-recovery loop filter: lock detection, gain
// scheduling (acquisition/tracking) and NCO start-frequency sweep on acquisition timeout.
module carrier_loop_ctrl #(
  parameter int INIT_FREQ     = 178849019,
  parameter int FREQ_MIN      = 178000000,
  parameter int FREQ_MAX      = 179700000,
  parameter int SWEEP_STEP    = 200000,
  parameter int KP_ACQ        = 2,
  parameter int KI_ACQ        = 8,
  parameter int KP_TRK        = 4,
  parameter int KI_TRK        = 12,
  parameter int LOCK_THRESH   = 1 << 20,
  parameter int UNLOCK_THRESH = 1 << 23,
  parameter int LOCK_COUNT    = 256,
  parameter int UNLOCK_COUNT  = 64,
  parameter int ACQ_TIMEOUT   = 8192,
  parameter int SETTLE        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        valid,
  input  logic [31:0] phase_error,
  output logic [4:0]  kp_shift,
  output logic [4:0]  ki_shift,
  output logic        freq_load,
  output logic [31:0] freq_load_val,
  output logic        locked,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    SWEEP = 2'd2,
    TRACK = 2'd3
  } state_t;

  localparam logic [15:0] LOCK_C   = 16'(LOCK_COUNT);
  localparam logic [15:0] UNLOCK_C = 16'(UNLOCK_COUNT);
  localparam logic [15:0] TIMEOUT_C = 16'(ACQ_TIMEOUT);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [31:0] LOCK_T   = 32'(LOCK_THRESH);
  localparam logic [31:0] UNLOCK_T = 32'(UNLOCK_THRESH);
  localparam logic [32:0] FMAX_C   = 33'(FREQ_MAX);
  localparam logic [32:0] STEP_C   = 33'(SWEEP_STEP);

  state_t      state_reg, state_next;
  logic [15:0] settle_reg, settle_next;
  logic [15:0] good_reg, good_next;
  logic [15:0] timer_reg, timer_next;
  logic [15:0] bad_reg, bad_next;
  logic        load_reg, load_next;
  logic [31:0] val_reg, val_next;
  logic        locked_reg;
  logic [4:0]  kp_reg, ki_reg;
  logic [31:0] mag;
  logic [32:0] sum;

  // Magnitude with the most negative value saturated so it stays representable.
  always_comb begin
    mag = phase_error;
    if (phase_error[31]) begin
      mag = (phase_error == 32'h8000_0000) ? 32'h7fff_ffff : (~phase_error + 32'd1);
    end
  end

  assign sum = {1'b0, val_reg} + STEP_C;

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    good_next   = good_reg;
    timer_next  = timer_reg;
    bad_next    = bad_reg;
    load_next   = 1'b0;
    val_next    = val_reg;
    if (!enable) begin
      state_next  = IDLE;
      settle_next = '0;
      good_next   = '0;
      timer_next  = '0;
      bad_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = SWEEP;
          load_next   = 1'b1;
          val_next    = 32'(INIT_FREQ);
          settle_next = '0;
        end
        SWEEP: if (valid) begin
          if (settle_reg == SETTLE_LAST) begin
            state_next = ACQ;
            good_next  = '0;
            timer_next = '0;
          end else begin
            settle_next = settle_reg + 16'd1;
          end
        end
        ACQ: if (valid) begin
          good_next  = (mag < LOCK_T) ? good_reg + 16'd1 : 16'd0;
          timer_next = timer_reg + 16'd1;
          // Lock takes precedence over a timeout on the same sample.
          if (good_next == LOCK_C) begin
            state_next = TRACK;
            bad_next   = '0;
          end else if (timer_next == TIMEOUT_C) begin
            state_next  = SWEEP;
            load_next   = 1'b1;
            val_next    = (sum > FMAX_C) ? 32'(FREQ_MIN) : sum[31:0];
            settle_next = '0;
          end
        end
        TRACK: if (valid) begin
          bad_next = (mag >= UNLOCK_T) ? bad_reg + 16'd1 : 16'd0;
          if (bad_next == UNLOCK_C) begin
            state_next = ACQ;
            good_next  = '0;
            timer_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      settle_reg <= '0;
      good_reg   <= '0;
      timer_reg  <= '0;
      bad_reg    <= '0;
      load_reg   <= 1'b0;
      val_reg    <= 32'(INIT_FREQ);
      locked_reg <= 1'b0;
      kp_reg     <= 5'(KP_ACQ);
      ki_reg     <= 5'(KI_ACQ);
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      good_reg   <= good_next;
      timer_reg  <= timer_next;
      bad_reg    <= bad_next;
      load_reg   <= load_next;
      val_reg    <= val_next;
      locked_reg <= (state_next == TRACK);
      kp_reg     <= (state_next == TRACK) ? 5'(KP_TRK) : 5'(KP_ACQ);
      ki_reg     <= (state_next == TRACK) ? 5'(KI_TRK) : 5'(KI_ACQ);
    end
  end

  assign state         = state_reg;
  assign kp_shift      = kp_reg;
  assign ki_shift      = ki_reg;
  assign freq_load     = load_reg;
  assign freq_load_val = val_reg;
  assign locked        = locked_reg;

endmodule
